// File: rtl/fp_fixp_split.sv
// fp_fixp_split
//   Upstream feeder of the fixed-point accumulator kernel. Splits each IEEE-754
//   binary64 operand into a chunk index and a 128-bit aligned mantissa, so that
//   |x| = data * 2^(64*cs - 1074). The sign travels on a sideband. Zeros and
//   Inf/NaN are dropped in S1 and leave a bubble. Inf/NaN also set a sticky
//   error flag.
//   The pipeline has two registered stages with valid/ready handshakes. It
//   accepts one element per clock and loses nothing under backpressure.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   in_tdata/tvalid/tready    binary64 operand stream (slave)
//   out_tdata/tvalid/tready   {cs[CS_W-1:0], data[PRE_REG_WIDTH-1:0]} (master)
//   out_sign         sign of the element on out_tdata, valid with out_tvalid
//   clr              1-clk pulse: clears err_special and the stats counters
//   busy             some pipeline stage holds an element
//   err_special      sticky, set when an Inf/NaN leaves S1
//
// Configuration
//   FIXP_SPLIT_STATS_EN  adds cnt_out / cnt_zero / cnt_special (32-bit, wrapping)
module fp_fixp_split #(
    parameter int FP_EXP_W      = 11,
    parameter int FP_MAN_W      = 52,
    parameter int DEPTH         = 32,
    parameter int PRE_REG_WIDTH = 128,
    parameter int PRE_REG_STEP  = 64,
    localparam int CS_W         = $clog2(DEPTH),
    localparam int FP_W         = 1 + FP_EXP_W + FP_MAN_W
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [FP_W-1:0]               in_tdata,
    input  logic                          in_tvalid,
    output logic                          in_tready,
    output logic [PRE_REG_WIDTH+CS_W-1:0] out_tdata,
    output logic                          out_tvalid,
    input  logic                          out_tready,
    output logic                          out_sign,
    input  logic                          clr,
    output logic                          busy,
    output logic                          err_special
`ifdef FIXP_SPLIT_STATS_EN
    ,
    output logic [31:0]                   cnt_out,
    output logic [31:0]                   cnt_zero,
    output logic [31:0]                   cnt_special
`endif
);

    localparam int SH_W = $clog2(PRE_REG_STEP);

    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_SPEC = 2'd2;

    // ---- S1 decode (combinational front of the register) ----
    logic [FP_EXP_W-1:0] in_e;
    logic [FP_MAN_W-1:0] in_f;
    logic [FP_MAN_W:0]   in_m;
    logic [FP_EXP_W-1:0] in_p;
    logic [1:0]          in_cls;

    assign in_e = in_tdata[FP_W-2 -: FP_EXP_W];
    assign in_f = in_tdata[FP_MAN_W-1:0];
    // The hidden bit is set only for normals. Subnormals share the weight of
    // e==1, so p is clamped at 0.
    assign in_m = {|in_e, in_f};
    assign in_p = (in_e == '0) ? '0 : in_e - FP_EXP_W'(1);

    always_comb begin
        in_cls = CLS_NORM;
        if (&in_e)                           in_cls = CLS_SPEC;
        else if (in_e == '0 && in_f == '0)   in_cls = CLS_ZERO;
    end

    // ---- handshake ----
    logic s1_v, s2_v, rdy_en;
    logic s1_adv, s2_adv, in_hs;

    assign s2_adv    = ~s2_v | out_tready;
    assign s1_adv    = ~s1_v | s2_adv;
    // rdy_en holds in_tready low during reset and until the first clock edge
    // after reset is released.
    assign in_tready = rdy_en & s1_adv;
    assign in_hs     = in_tvalid & in_tready;

    // ---- S1 register ----
    logic                s1_s;
    logic [FP_MAN_W:0]   s1_m;
    logic [FP_EXP_W-1:0] s1_p;
    logic [1:0]          s1_cls;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_en <= 1'b0;
            s1_v   <= 1'b0;
            s1_s   <= 1'b0;
            s1_m   <= '0;
            s1_p   <= '0;
            s1_cls <= CLS_NORM;
        end else begin
            rdy_en <= 1'b1;
            if (s1_adv) s1_v <= in_hs;
            if (in_hs) begin
                s1_s   <= in_tdata[FP_W-1];
                s1_m   <= in_m;
                s1_p   <= in_p;
                s1_cls <= in_cls;
            end
        end
    end

    // ---- S1 -> S2 ----
    logic                     s1_fwd, zero_drop, spec_drop, out_hs;
    logic [PRE_REG_WIDTH-1:0] s1_data;

    assign s1_fwd    = s1_v & s2_adv & (s1_cls == CLS_NORM);
    assign zero_drop = s1_v & s2_adv & (s1_cls == CLS_ZERO);
    assign spec_drop = s1_v & s2_adv & (s1_cls == CLS_SPEC);
    assign out_hs    = s2_v & out_tready;

    // Highest set bit is FP_MAN_W + PRE_REG_STEP-1, which fits in PRE_REG_WIDTH.
    // The shift therefore never truncates.
    assign s1_data = {{(PRE_REG_WIDTH-FP_MAN_W-1){1'b0}}, s1_m} << s1_p[SH_W-1:0];

    // ---- S2 register ----
    logic [CS_W-1:0]          s2_cs;
    logic [PRE_REG_WIDTH-1:0] s2_data;
    logic                     s2_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_v    <= 1'b0;
            s2_cs   <= '0;
            s2_data <= '0;
            s2_s    <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_fwd;
            // Load only real elements. Bubbles leave the old data in place.
            if (s1_fwd) begin
                s2_cs   <= s1_p[SH_W +: CS_W];
                s2_data <= s1_data;
                s2_s    <= s1_s;
            end
        end
    end

    assign out_tvalid = s2_v;
    assign out_tdata  = {s2_cs, s2_data};
    assign out_sign   = s2_s;
    assign busy       = s1_v | s2_v;

    // A set in the same cycle as clr takes priority over the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          err_special <= 1'b0;
        else if (spec_drop) err_special <= 1'b1;
        else if (clr)       err_special <= 1'b0;
    end

`ifdef FIXP_SPLIT_STATS_EN
    // When clr and an increment arrive together, the counter restarts at 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_out     <= '0;
            cnt_zero    <= '0;
            cnt_special <= '0;
        end else if (clr) begin
            cnt_out     <= 32'(out_hs);
            cnt_zero    <= 32'(zero_drop);
            cnt_special <= 32'(spec_drop);
        end else begin
            cnt_out     <= cnt_out     + 32'(out_hs);
            cnt_zero    <= cnt_zero    + 32'(zero_drop);
            cnt_special <= cnt_special + 32'(spec_drop);
        end
    end
`endif

endmodule
